// File: rtl/id_hazard_scoreboard_pkg.sv
// id_hazard_scoreboard_pkg: shared widths, zero-register index and tracking entry type
package id_hazard_scoreboard_pkg;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam logic [AW-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic          v;
        logic          we;
        logic [AW-1:0] dest;
        logic          ld;
    } entry_t;

endpackage

// File: rtl/id_hazard_scoreboard_hz_src_match.sv
// hz_src_match: resolves one source operand against the downstream destination entries
module hz_src_match
    import id_hazard_scoreboard_pkg::*;
#(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int NSTG   = 3,
    parameter int LD_STG = 1
) (
    input  logic               en_i,
    input  logic [AW-1:0]      addr_i,
    input  logic [DW-1:0]      rdata_i,
    input  entry_t [NSTG-1:0]  ent_i,
    input  logic [NSTG*DW-1:0] stg_data_i,
    output logic [DW-1:0]      value_o,
    output logic               not_ready_o
);

    logic [NSTG-1:0] hit;

    for (genvar i = 0; i < NSTG; i++) begin : g_hit
        assign hit[i] = en_i && (addr_i != ZERO_REG) && ent_i[i].v && ent_i[i].we
                        && (ent_i[i].dest == addr_i);
    end

    // scan oldest to youngest so the youngest matching stage has the final say
    always_comb begin
        value_o     = rdata_i;
        not_ready_o = 1'b0;
        for (int i = NSTG - 1; i >= 0; i--) begin
            if (hit[i]) begin
                value_o     = stg_data_i[i*DW +: DW];
                not_ready_o = ent_i[i].ld && (i < LD_STG);
            end
        end
    end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// id_hazard_scoreboard: ID pipeline register, downstream destination tracking, forwarding and hazard stall
module id_hazard_scoreboard
    import id_hazard_scoreboard_pkg::*;
#(
    parameter int PW     = 64,
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int NSRC   = 3,
    parameter int NSTG   = 3,
    parameter int LD_STG = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               if_valid,
    input  logic [PW-1:0]      if_data,
    output logic               id_allow_in,
    output logic               id_valid,
    output logic [PW-1:0]      id_data,
    output logic               id_to_ex_valid,
    input  logic               ex_allow_in,
    input  logic               br_flush,
    input  logic               flush_all,
    input  logic [NSRC-1:0]    id_src_en,
    input  logic [NSRC*AW-1:0] id_src_addr,
    input  logic [AW-1:0]      id_dest,
    input  logic               id_we,
    input  logic               id_is_load,
    input  logic [NSRC*DW-1:0] rf_rdata,
    input  logic [NSTG-1:0]    stg_adv,
    input  logic [NSTG*DW-1:0] stg_data,
    output logic [NSRC*DW-1:0] src_value,
    output logic               hz_stall,
    output logic [31:0]        stall_cnt
);

    entry_t [NSTG-1:0] ent_q, ent_d;
    entry_t            new_ent;
    logic              id_valid_q, id_valid_d;
    logic [PW-1:0]     id_data_q, id_data_d;
    logic [31:0]       stall_cnt_q, stall_cnt_d;
    logic [NSRC-1:0]   not_ready;
    logic              ready_go;
    logic              id_fire;

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        hz_src_match #(
            .DW     (DW),
            .AW     (AW),
            .NSTG   (NSTG),
            .LD_STG (LD_STG)
        ) u_match (
            .en_i        (id_src_en[s]),
            .addr_i      (id_src_addr[s*AW +: AW]),
            .rdata_i     (rf_rdata[s*DW +: DW]),
            .ent_i       (ent_q),
            .stg_data_i  (stg_data),
            .value_o     (src_value[s*DW +: DW]),
            .not_ready_o (not_ready[s])
        );
    end

    assign hz_stall       = id_valid_q & (|not_ready);
    assign ready_go       = id_valid_q & ~hz_stall;
    assign id_to_ex_valid = ready_go;
    assign id_allow_in    = ~id_valid_q | (ready_go & ex_allow_in);
    assign id_fire        = ready_go & ex_allow_in;
    assign id_valid       = id_valid_q;
    assign id_data        = id_data_q;
    assign stall_cnt      = stall_cnt_q;
    assign new_ent        = '{v: 1'b1, we: id_we, dest: id_dest, ld: id_is_load};

    // ID register next state: flushes kill the slot, otherwise refill when allowed
    always_comb begin
        id_valid_d  = (flush_all | br_flush) ? 1'b0 : id_allow_in ? if_valid : id_valid_q;
        id_data_d   = (if_valid & id_allow_in) ? if_data : id_data_q;
        stall_cnt_d = stall_cnt_q + {31'd0, hz_stall};
    end

    // tracking entries shift with their stages; an issued instruction enters EX unless globally flushed
    always_comb begin
        ent_d    = ent_q;
        ent_d[0] = id_fire ? new_ent : stg_adv[0] ? '0 : ent_q[0];
        for (int i = 1; i < NSTG; i++) begin
            ent_d[i] = stg_adv[i-1] ? ent_q[i-1] : stg_adv[i] ? '0 : ent_q[i];
        end
        if (flush_all) ent_d = '0;
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            id_valid_q  <= 1'b0;
            id_data_q   <= '0;
            ent_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            id_valid_q  <= id_valid_d;
            id_data_q   <= id_data_d;
            ent_q       <= ent_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// tb_id_hazard_scoreboard: directed vectors checked against an instruction-level reference model
module tb_id_hazard_scoreboard;

    localparam int PW = 64, DW = 32, AW = 5, NSRC = 3, NSTG = 3, LD_STG = 1;

    logic               clk = 1'b0;
    logic               reset, if_valid, ex_allow_in, br_flush, flush_all;
    logic               id_we, id_is_load;
    logic [PW-1:0]      if_data;
    logic [NSRC-1:0]    id_src_en;
    logic [NSRC*AW-1:0] id_src_addr;
    logic [AW-1:0]      id_dest;
    logic [NSRC*DW-1:0] rf_rdata;
    logic [NSTG-1:0]    stg_adv;
    logic [NSTG*DW-1:0] stg_data;
    logic               id_allow_in, id_valid, id_to_ex_valid, hz_stall;
    logic [PW-1:0]      id_data;
    logic [NSRC*DW-1:0] src_value;
    logic [31:0]        stall_cnt;

    always #5 clk = ~clk;

    id_hazard_scoreboard #(
        .PW(PW), .DW(DW), .AW(AW), .NSRC(NSRC), .NSTG(NSTG), .LD_STG(LD_STG)
    ) dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_data(if_data),
        .id_allow_in(id_allow_in), .id_valid(id_valid), .id_data(id_data),
        .id_to_ex_valid(id_to_ex_valid), .ex_allow_in(ex_allow_in),
        .br_flush(br_flush), .flush_all(flush_all), .id_src_en(id_src_en),
        .id_src_addr(id_src_addr), .id_dest(id_dest), .id_we(id_we),
        .id_is_load(id_is_load), .rf_rdata(rf_rdata), .stg_adv(stg_adv),
        .stg_data(stg_data), .src_value(src_value), .hz_stall(hz_stall),
        .stall_cnt(stall_cnt)
    );

    int checks = 0;
    int errors = 0;
    bit started = 0;

    // reference model: one slot per in-flight instruction position
    bit            mv[NSTG], mwe[NSTG], mld[NSTG];
    int            mdest[NSTG];
    bit            mval;
    logic [PW-1:0] mdata;
    logic [31:0]   mcnt;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_out(output logic [NSRC*DW-1:0] val, output bit stall);
        stall = 0;
        val   = rf_rdata;
        for (int s = 0; s < NSRC; s++) begin
            int a;
            bit found;
            a     = int'(id_src_addr[s*AW +: AW]);
            found = 0;
            if (id_src_en[s] && a != 0) begin
                for (int i = 0; i < NSTG; i++) begin
                    if (!found && mv[i] && mwe[i] && mdest[i] == a) begin
                        found = 1;
                        val[s*DW +: DW] = stg_data[i*DW +: DW];
                        if (mld[i] && i < LD_STG) stall = 1;
                    end
                end
            end
        end
        stall = stall && mval;
    endfunction

    always @(posedge clk) begin : model
        logic [NSRC*DW-1:0] v;
        bit st, fire, allow;
        bit nv[NSTG], nwe[NSTG], nld[NSTG];
        int nd[NSTG];
        model_out(v, st);
        fire  = mval && !st && ex_allow_in;
        allow = !mval || fire;
        if (reset) begin
            for (int i = 0; i < NSTG; i++) mv[i] = 0;
            mval = 0;
            mdata = '0;
            mcnt = '0;
        end else begin
            if (st) mcnt = mcnt + 1;
            for (int i = 0; i < NSTG; i++) begin
                nv[i] = 0; nwe[i] = 0; nld[i] = 0; nd[i] = 0;
            end
            for (int i = 0; i < NSTG; i++)
                if (mv[i] && !stg_adv[i]) begin
                    nv[i] = 1; nwe[i] = mwe[i]; nld[i] = mld[i]; nd[i] = mdest[i];
                end
            for (int i = 0; i < NSTG - 1; i++)
                if (mv[i] && stg_adv[i]) begin
                    nv[i+1] = 1; nwe[i+1] = mwe[i]; nld[i+1] = mld[i]; nd[i+1] = mdest[i];
                end
            if (fire) begin
                nv[0] = 1; nwe[0] = id_we; nld[0] = id_is_load; nd[0] = int'(id_dest);
            end
            for (int i = 0; i < NSTG; i++) begin
                mv[i] = nv[i] && !flush_all; mwe[i] = nwe[i]; mld[i] = nld[i]; mdest[i] = nd[i];
            end
            if (flush_all || br_flush) mval = 0;
            else if (allow) mval = if_valid;
            if (if_valid && allow) mdata = if_data;
        end
    end

    always @(negedge clk) begin : compare
        logic [NSRC*DW-1:0] ev;
        bit es;
        if (started) begin
            model_out(ev, es);
            chk("id_valid", id_valid, mval);
            chk("hz_stall", hz_stall, es);
            chk("id_to_ex_valid", id_to_ex_valid, mval && !es);
            chk("id_allow_in", id_allow_in, !mval || (!es && ex_allow_in));
            chk("stall_cnt", stall_cnt, mcnt);
            for (int s = 0; s < NSRC; s++) chk("src_value", src_value[s*DW +: DW], ev[s*DW +: DW]);
            if (mval) chk("id_data", id_data, mdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic srcset(int s, bit en, int a);
        id_src_en[s] = en;
        id_src_addr[s*AW +: AW] = a[AW-1:0];
    endtask

    task automatic idinst(bit we, int d, bit ld);
        id_we = we;
        id_dest = d[AW-1:0];
        id_is_load = ld;
    endtask

    task automatic drain();
        if_valid = 0;
        idinst(0, 0, 0);
        id_src_en = '0;
        stg_adv = '1;
        repeat (4) tick();
        stg_adv = '0;
    endtask

    initial begin
        reset = 1; if_valid = 0; if_data = '0; ex_allow_in = 1; br_flush = 0; flush_all = 0;
        id_src_en = '0; id_src_addr = '0; id_dest = '0; id_we = 0; id_is_load = 0;
        rf_rdata = '0; stg_adv = '0; stg_data = '0;
        tick(); tick();
        started = 1;
        @(negedge clk);
        chk("rst_id_valid", id_valid, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_allow_in", id_allow_in, 1);
        reset = 0;
        rf_rdata = {32'h333, 32'h222, 32'h111};

        // ALU result forwarded from EX
        if_valid = 1; if_data = 64'hA; tick();
        idinst(1, 4, 0); if_data = 64'hB; tick();
        idinst(0, 0, 0); if_valid = 0; srcset(0, 1, 4); stg_data = {32'h0, 32'h0, 32'h1234};
        @(negedge clk);
        chk("alu_fwd_stall", hz_stall, 0);
        chk("alu_fwd_value", src_value[31:0], 32'h1234);
        chk("alu_fwd_issue", id_to_ex_valid, 1);
        stg_adv = 3'b111; tick();
        drain();

        // load-use stall for one cycle, then forward from ME
        if_valid = 1; if_data = 64'hC; tick();
        idinst(1, 5, 1); if_data = 64'hD; tick();
        idinst(0, 0, 0); if_valid = 0; srcset(0, 1, 5); stg_adv = 3'b001;
        stg_data = {32'h0, 32'hCAFE, 32'hBAD0};
        @(negedge clk);
        chk("ldu_stall", hz_stall, 1);
        chk("ldu_no_issue", id_to_ex_valid, 0);
        chk("ldu_allow_in", id_allow_in, 0);
        tick(); stg_adv = '0;
        @(negedge clk);
        chk("ldu_release", hz_stall, 0);
        chk("ldu_value", src_value[31:0], 32'hCAFE);
        chk("ldu_cnt", stall_cnt, 1);
        tick();
        drain();

        // youngest match wins, r0 never forwards
        if_valid = 1; if_data = 64'hE; tick();
        idinst(1, 7, 0); if_data = 64'hF; tick();
        stg_adv = 3'b001; if_data = 64'h10; tick();
        stg_adv = '0; if_data = 64'h11; idinst(1, 0, 0);
        srcset(0, 1, 7); srcset(1, 1, 0); stg_data = {32'h3, 32'h2, 32'h1};
        @(negedge clk);
        chk("young_ex", src_value[31:0], 32'h1);
        chk("r0_rf_a", src_value[63:32], 32'h222);
        stg_adv = 3'b011; tick();

        // backpressure holds ID and loads nothing into EX tracking
        stg_adv = '0; ex_allow_in = 0; if_data = 64'h12; idinst(1, 9, 0); srcset(2, 1, 9);
        @(negedge clk);
        chk("young_me", src_value[31:0], 32'h2);
        chk("r0_rf_b", src_value[63:32], 32'h222);
        chk("bp_allow_in", id_allow_in, 0);
        tick();
        @(negedge clk);
        chk("bp_data_hold", id_data, 64'h11);
        chk("bp_no_load", src_value[95:64], 32'h333);
        ex_allow_in = 1; stg_adv = 3'b111; tick();

        // branch flush drops the incoming payload
        idinst(0, 0, 0); srcset(0, 1, 9); srcset(1, 0, 0); srcset(2, 0, 0);
        br_flush = 1; if_data = 64'h13;
        @(negedge clk);
        chk("bp_single_issue", id_data, 64'h12);
        chk("bp_fwd_r9", src_value[31:0], 32'h1);
        tick();
        br_flush = 0; if_valid = 0; stg_adv = '0;
        @(negedge clk);
        chk("brf_id_valid", id_valid, 0);

        // global flush while issuing clears all tracking
        if_valid = 1; if_data = 64'h14; tick();
        idinst(1, 10, 0); flush_all = 1; if_valid = 0;
        @(negedge clk);
        chk("fa_issue", id_to_ex_valid, 1);
        tick();
        flush_all = 0; idinst(0, 0, 0); if_valid = 1; if_data = 64'h15;
        @(negedge clk);
        chk("fa_id_valid", id_valid, 0);
        tick();
        if_valid = 0; srcset(0, 1, 10); srcset(1, 1, 9);
        @(negedge clk);
        chk("fa_r10_rf", src_value[31:0], 32'h111);
        chk("fa_r9_rf", src_value[63:32], 32'h222);
        tick();
        drain();

        // reset in the middle of a load-use stall
        if_valid = 1; if_data = 64'h16; tick();
        idinst(1, 11, 1); if_data = 64'h17; tick();
        idinst(0, 0, 0); if_valid = 0; srcset(0, 1, 11);
        @(negedge clk);
        chk("rs_stall_a", hz_stall, 1);
        tick();
        @(negedge clk);
        chk("rs_stall_b", hz_stall, 1);
        chk("rs_cnt", stall_cnt, 2);
        reset = 1; tick();
        @(negedge clk);
        chk("rs_id_valid", id_valid, 0);
        chk("rs_hz_stall", hz_stall, 0);
        chk("rs_stall_cnt", stall_cnt, 0);
        reset = 0; id_src_en = '0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
